// File: rtl/sysblock_int.sv
// sysblock_int: one processing element of a systolic MAC array.
// Operands pass through to the right and downward with one cycle of delay.
// Valid operand pairs are multiplied and accumulated in ACC_W bits, with
// optional saturation. A drain request reads the accumulator out onto a
// column result chain. Non-head elements then forward words from the element
// above until the last word of the chain has passed.
module sysblock_int #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16,
  parameter int SAT    = 1,
  parameter int TOP    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] up,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] left,
  input  logic              left_valid,
  input  logic              clear,
  input  logic              drain,
  input  logic [ACC_W-1:0]  res_in,
  input  logic              res_in_valid,
  input  logic              res_in_last,
  output logic [DATA_W-1:0] down,
  output logic              down_valid,
  output logic [DATA_W-1:0] right,
  output logic              right_valid,
  output logic [ACC_W-1:0]  res,
  output logic              res_valid,
  output logic              res_last,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              skew_err,
  output logic              busy
);

  typedef enum logic {ST_ACC = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     skew_err_q, skew_err_d;
  logic [DATA_W-1:0]        down_q, down_d;
  logic                     down_valid_q, down_valid_d;
  logic [DATA_W-1:0]        right_q, right_d;
  logic                     right_valid_q, right_valid_d;
  logic [ACC_W-1:0]         res_q, res_d;
  logic                     res_valid_q, res_valid_d;
  logic                     res_last_q, res_last_d;

  logic signed [DATA_W-1:0]   up_s;
  logic signed [DATA_W-1:0]   left_s;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_base;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    acc_mac;
  logic [CNT_W-1:0]           count_base;
  logic [CNT_W-1:0]           count_mac;
  logic                       ovf_base;
  logic                       skew_base;
  logic                       add_ovf;
  logic                       ovf_mac;
  logic                       skew_mac;
  logic                       pair;
  logic                       skew;
  logic                       last_word;

  // Signed overflow of a + b = s: operands agree in sign, result does not.
  function automatic logic add_overflows(input logic signed [ACC_W-1:0] a,
                                         input logic signed [ACC_W-1:0] b,
                                         input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  // Clamp an overflowed sum toward the side the addends were on (SAT only).
  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W-1:0] s,
                                                       input logic                    of,
                                                       input logic                    neg);
    if (of && (SAT != 0)) begin
      if (neg) return {1'b1, {(ACC_W-1){1'b0}}};
      else     return {1'b0, {(ACC_W-1){1'b1}}};
    end
    return s;
  endfunction

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign up_s      = up;
  assign left_s    = left;
  assign pair      = up_valid & left_valid;
  assign skew      = up_valid ^ left_valid;
  assign last_word = res_in_valid & res_in_last;

  // MAC candidate: clear restarts from zero before this cycle's pair is added.
  always_comb begin
    prod       = (2*DATA_W)'(up_s) * (2*DATA_W)'(left_s);
    prod_ext   = (ACC_W)'(prod);
    acc_base   = clear ? '0 : acc_q;
    count_base = clear ? '0 : count_q;
    ovf_base   = clear ? 1'b0 : ovf_q;
    skew_base  = clear ? 1'b0 : skew_err_q;
    sum        = acc_base + prod_ext;
    add_ovf    = pair & add_overflows(acc_base, prod_ext, sum);
    acc_mac    = pair ? saturate(sum, add_ovf, acc_base[ACC_W-1]) : acc_base;
    count_mac  = pair ? count_inc(count_base) : count_base;
    ovf_mac    = ovf_base | add_ovf;
    skew_mac   = skew_base | skew;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_ACC;
    else      state_q <= state_d;
  end

  // FSM next state: a head element drains one word, others wait for the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:   if (drain) state_d = ST_DRAIN;
      ST_DRAIN: if ((TOP != 0) || last_word) state_d = ST_ACC;
      default:  state_d = ST_ACC;
    endcase
  end

  // FSM outputs and datapath next values; operands always pass through.
  always_comb begin
    down_d        = up;
    down_valid_d  = up_valid;
    right_d       = left;
    right_valid_d = left_valid;
    acc_d         = acc_q;
    count_d       = count_q;
    ovf_d         = ovf_q;
    skew_err_d    = skew_err_q;
    res_d         = res_q;
    res_valid_d   = 1'b0;
    res_last_d    = 1'b0;
    case (state_q)
      ST_ACC: begin
        acc_d      = acc_mac;
        count_d    = count_mac;
        ovf_d      = ovf_mac;
        skew_err_d = skew_mac;
        if (drain) begin
          res_d       = acc_mac;
          res_valid_d = 1'b1;
          res_last_d  = (TOP != 0);
        end
      end
      ST_DRAIN: begin
        if (TOP == 0) begin
          res_d       = res_in;
          res_valid_d = res_in_valid;
          res_last_d  = last_word;
        end
        if (state_d == ST_ACC) begin
          acc_d      = '0;
          count_d    = '0;
          ovf_d      = 1'b0;
          skew_err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q         <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      skew_err_q    <= 1'b0;
      down_q        <= '0;
      down_valid_q  <= 1'b0;
      right_q       <= '0;
      right_valid_q <= 1'b0;
      res_q         <= '0;
      res_valid_q   <= 1'b0;
      res_last_q    <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      skew_err_q    <= skew_err_d;
      down_q        <= down_d;
      down_valid_q  <= down_valid_d;
      right_q       <= right_d;
      right_valid_q <= right_valid_d;
      res_q         <= res_d;
      res_valid_q   <= res_valid_d;
      res_last_q    <= res_last_d;
    end
  end

  assign down        = down_q;
  assign down_valid  = down_valid_q;
  assign right       = right_q;
  assign right_valid = right_valid_q;
  assign res         = res_q;
  assign res_valid   = res_valid_q;
  assign res_last    = res_last_q;
  assign count       = count_q;
  assign ovf         = ovf_q;
  assign skew_err    = skew_err_q;
  assign busy        = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_sysblock_int.sv
// tb_sysblock_int: directed vectors for the systolic MAC element.
// u_a head element (defaults), u_b chain element (TOP=0, own drain/res_in),
// u_c 2-bit counter, u_s1/u_s0 16-bit accumulator saturating/wrapping.
module tb_sysblock_int;

  logic clk;
  logic rst;
  logic [7:0] up, left;
  logic up_valid, left_valid, clear, drain;
  logic drain_b;
  logic [31:0] res_in_b;
  logic res_in_valid_b, res_in_last_b;
  logic [31:0] z32;
  logic [15:0] z16;
  logic zero1;

  logic [7:0]  a_down, a_right;  logic a_dv, a_rv;  logic [31:0] a_res;
  logic a_rvld, a_rlast, a_ovf, a_skew, a_busy;     logic [15:0] a_count;
  logic [7:0]  b_down, b_right;  logic b_dv, b_rv;  logic [31:0] b_res;
  logic b_rvld, b_rlast, b_ovf, b_skew, b_busy;     logic [15:0] b_count;
  logic [7:0]  c_down, c_right;  logic c_dv, c_rv;  logic [31:0] c_res;
  logic c_rvld, c_rlast, c_ovf, c_skew, c_busy;     logic [1:0]  c_count;
  logic [7:0]  s1_down, s1_right; logic s1_dv, s1_rv; logic [15:0] s1_res;
  logic s1_rvld, s1_rlast, s1_ovf, s1_skew, s1_busy; logic [15:0] s1_count;
  logic [7:0]  s0_down, s0_right; logic s0_dv, s0_rv; logic [15:0] s0_res;
  logic s0_rvld, s0_rlast, s0_ovf, s0_skew, s0_busy; logic [15:0] s0_count;

  int n_chk;
  int n_fail;

  sysblock_int #(.TOP(1)) u_a (
    .clk(clk), .rst(rst), .up(up), .up_valid(up_valid), .left(left), .left_valid(left_valid),
    .clear(clear), .drain(drain), .res_in(z32), .res_in_valid(zero1), .res_in_last(zero1),
    .down(a_down), .down_valid(a_dv), .right(a_right), .right_valid(a_rv),
    .res(a_res), .res_valid(a_rvld), .res_last(a_rlast), .count(a_count),
    .ovf(a_ovf), .skew_err(a_skew), .busy(a_busy));

  sysblock_int u_b (
    .clk(clk), .rst(rst), .up(up), .up_valid(up_valid), .left(left), .left_valid(left_valid),
    .clear(clear), .drain(drain_b), .res_in(res_in_b), .res_in_valid(res_in_valid_b),
    .res_in_last(res_in_last_b),
    .down(b_down), .down_valid(b_dv), .right(b_right), .right_valid(b_rv),
    .res(b_res), .res_valid(b_rvld), .res_last(b_rlast), .count(b_count),
    .ovf(b_ovf), .skew_err(b_skew), .busy(b_busy));

  sysblock_int #(.CNT_W(2), .TOP(1)) u_c (
    .clk(clk), .rst(rst), .up(up), .up_valid(up_valid), .left(left), .left_valid(left_valid),
    .clear(clear), .drain(drain), .res_in(z32), .res_in_valid(zero1), .res_in_last(zero1),
    .down(c_down), .down_valid(c_dv), .right(c_right), .right_valid(c_rv),
    .res(c_res), .res_valid(c_rvld), .res_last(c_rlast), .count(c_count),
    .ovf(c_ovf), .skew_err(c_skew), .busy(c_busy));

  sysblock_int #(.ACC_W(16), .SAT(1), .TOP(1)) u_s1 (
    .clk(clk), .rst(rst), .up(up), .up_valid(up_valid), .left(left), .left_valid(left_valid),
    .clear(clear), .drain(drain), .res_in(z16), .res_in_valid(zero1), .res_in_last(zero1),
    .down(s1_down), .down_valid(s1_dv), .right(s1_right), .right_valid(s1_rv),
    .res(s1_res), .res_valid(s1_rvld), .res_last(s1_rlast), .count(s1_count),
    .ovf(s1_ovf), .skew_err(s1_skew), .busy(s1_busy));

  sysblock_int #(.ACC_W(16), .SAT(0), .TOP(1)) u_s0 (
    .clk(clk), .rst(rst), .up(up), .up_valid(up_valid), .left(left), .left_valid(left_valid),
    .clear(clear), .drain(drain), .res_in(z16), .res_in_valid(zero1), .res_in_last(zero1),
    .down(s0_down), .down_valid(s0_dv), .right(s0_right), .right_valid(s0_rv),
    .res(s0_res), .res_valid(s0_rvld), .res_last(s0_rlast), .count(s0_count),
    .ovf(s0_ovf), .skew_err(s0_skew), .busy(s0_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0]  up;
    logic               uv;
    logic signed [7:0]  left;
    logic               lv;
    logic               clr;
    logic               drn;
    logic [15:0]        cnt;
    logic               skew;
    logic               busy;
    logic               rv;
    logic signed [63:0] res;
  } vec_t;

  function automatic vec_t mk(input int u, input int uv, input int l, input int lv,
                              input int clr, input int drn, input int cnt, input int skew,
                              input int busy, input int rv, input int res);
    vec_t v;
    v.up   = 8'(u);
    v.uv   = uv[0];
    v.left = 8'(l);
    v.lv   = lv[0];
    v.clr  = clr[0];
    v.drn  = drn[0];
    v.cnt  = 16'(cnt);
    v.skew = skew[0];
    v.busy = busy[0];
    v.rv   = rv[0];
    v.res  = 64'(res);
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    up = '0; left = '0; up_valid = 1'b0; left_valid = 1'b0;
    clear = 1'b0; drain = 1'b0; drain_b = 1'b0;
    res_in_b = '0; res_in_valid_b = 1'b0; res_in_last_b = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[14];

  initial begin
    n_chk = 0;
    n_fail = 0;
    z32 = '0;
    z16 = '0;
    zero1 = 1'b0;
    idle_inputs();
    rst = 1'b1;

    // head element: accumulate, drain, skew, clear, DRAIN-ignore behaviour
    tbl[0]  = mk(  3, 1,  4, 1, 0, 0, 1, 0, 0, 0,   0);
    tbl[1]  = mk( -2, 1,  5, 1, 0, 0, 2, 0, 0, 0,   0);
    tbl[2]  = mk(  0, 0,  0, 0, 0, 1, 2, 0, 1, 1,   2);
    tbl[3]  = mk(  0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0);
    tbl[4]  = mk(  9, 1,  0, 0, 0, 0, 0, 1, 0, 0,   0);
    tbl[5]  = mk( 10, 1, 10, 1, 0, 0, 1, 1, 0, 0,   0);
    tbl[6]  = mk(  0, 0,  0, 0, 0, 1, 1, 1, 1, 1, 100);
    tbl[7]  = mk(  5, 1,  5, 1, 1, 1, 0, 0, 0, 0,   0);
    tbl[8]  = mk( 10, 1, 10, 1, 0, 0, 1, 0, 0, 0,   0);
    tbl[9]  = mk(  6, 1, -3, 1, 1, 0, 1, 0, 0, 0,   0);
    tbl[10] = mk(  2, 1,  3, 1, 0, 1, 2, 0, 1, 1, -12);
    tbl[11] = mk( -1, 0,  7, 1, 0, 0, 0, 0, 0, 0,   0);
    tbl[12] = mk( -1, 0,  7, 1, 0, 0, 0, 1, 0, 0,   0);
    tbl[13] = mk(  0, 0,  0, 0, 1, 0, 0, 0, 0, 0,   0);

    // asynchronous reset: every output of every instance at zero before any clock
    #1 rst = 1'b0;
    #2;
    chk("rst_a_zero",  64'(|{a_down, a_dv, a_right, a_rv, a_res, a_rvld, a_rlast, a_count, a_ovf, a_skew, a_busy}), 0);
    chk("rst_b_zero",  64'(|{b_down, b_dv, b_right, b_rv, b_res, b_rvld, b_rlast, b_count, b_ovf, b_skew, b_busy}), 0);
    chk("rst_c_zero",  64'(|{c_down, c_dv, c_right, c_rv, c_res, c_rvld, c_rlast, c_count, c_ovf, c_skew, c_busy}), 0);
    chk("rst_s1_zero", 64'(|{s1_down, s1_dv, s1_right, s1_rv, s1_res, s1_rvld, s1_rlast, s1_count, s1_ovf, s1_skew, s1_busy}), 0);
    chk("rst_s0_zero", 64'(|{s0_down, s0_dv, s0_right, s0_rv, s0_res, s0_rvld, s0_rlast, s0_count, s0_ovf, s0_skew, s0_busy}), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      up = tbl[i].up; up_valid = tbl[i].uv;
      left = tbl[i].left; left_valid = tbl[i].lv;
      clear = tbl[i].clr; drain = tbl[i].drn;
      step();
      chk($sformatf("r%0d_count", i), 64'(a_count), 64'(tbl[i].cnt));
      chk($sformatf("r%0d_skew", i), 64'(a_skew), 64'(tbl[i].skew));
      chk($sformatf("r%0d_busy", i), 64'(a_busy), 64'(tbl[i].busy));
      chk($sformatf("r%0d_res_valid", i), 64'(a_rvld), 64'(tbl[i].rv));
      chk($sformatf("r%0d_res_last", i), 64'(a_rlast), 64'(tbl[i].rv));
      chk($sformatf("r%0d_ovf", i), 64'(a_ovf), 0);
      chk($sformatf("r%0d_down", i), 64'($signed(a_down)), 64'(tbl[i].up));
      chk($sformatf("r%0d_down_valid", i), 64'(a_dv), 64'(tbl[i].uv));
      chk($sformatf("r%0d_right", i), 64'($signed(a_right)), 64'(tbl[i].left));
      chk($sformatf("r%0d_right_valid", i), 64'(a_rv), 64'(tbl[i].lv));
      if (tbl[i].rv) chk($sformatf("r%0d_res", i), 64'($signed(a_res)), tbl[i].res);
    end
    idle_inputs();

    // overflow: three (127,127) pairs, 48387 overflows a 16-bit accumulator
    pulse_reset();
    up = 8'd127; left = 8'd127; up_valid = 1'b1; left_valid = 1'b1;
    step();
    step();
    chk("sat_cnt2", 64'(a_count), 2);
    chk("sat_s1_ovf_early", 64'(s1_ovf), 0);
    step();
    chk("sat_s1_ovf", 64'(s1_ovf), 1);
    chk("sat_s0_ovf", 64'(s0_ovf), 1);
    chk("sat_a_ovf", 64'(a_ovf), 0);
    chk("sat_a_cnt3", 64'(a_count), 3);
    chk("sat_c_cnt3", 64'(c_count), 3);
    up_valid = 1'b0; left_valid = 1'b0; drain = 1'b1;
    step();
    chk("sat_s1_res", 64'($signed(s1_res)), 32767);
    chk("sat_s0_res", 64'($signed(s0_res)), -17149);
    chk("sat_a_res", 64'($signed(a_res)), 48387);
    chk("sat_s0_res_valid", 64'(s0_rvld), 1);
    drain = 1'b0;
    step();
    chk("sat_leave_s1_ovf", 64'(s1_ovf), 0);
    chk("sat_leave_a_cnt", 64'(a_count), 0);

    // 2-bit counter holds at 3 while the 16-bit one keeps counting
    up = 8'd1; left = 8'd1; up_valid = 1'b1; left_valid = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("cntsat_c", 64'(c_count), 3);
    chk("cntsat_a", 64'(a_count), 5);
    up = 8'd127; left = 8'd127;
    for (int k = 0; k < 3; k++) step();
    chk("clr_pre_s0_ovf", 64'(s0_ovf), 1);
    up_valid = 1'b0; left_valid = 1'b0; clear = 1'b1;
    step();
    chk("clr_s0_ovf", 64'(s0_ovf), 0);
    chk("clr_c_cnt", 64'(c_count), 0);
    chk("clr_a_cnt", 64'(a_count), 0);
    clear = 1'b0;

    // chain element: own word 7, then forwarded 11 and 13 (last)
    pulse_reset();
    up = 8'd7; left = 8'd1; up_valid = 1'b1; left_valid = 1'b1;
    step();
    chk("chain_cnt1", 64'(b_count), 1);
    up_valid = 1'b0; left_valid = 1'b0; drain_b = 1'b1;
    step();
    chk("chain_w0_res", 64'($signed(b_res)), 7);
    chk("chain_w0_valid", 64'(b_rvld), 1);
    chk("chain_w0_last", 64'(b_rlast), 0);
    chk("chain_w0_busy", 64'(b_busy), 1);
    drain_b = 1'b0; res_in_b = 32'd11; res_in_valid_b = 1'b1;
    up = 8'd3; left = 8'd3; up_valid = 1'b1; left_valid = 1'b1;
    step();
    chk("chain_w1_res", 64'($signed(b_res)), 11);
    chk("chain_w1_valid", 64'(b_rvld), 1);
    chk("chain_w1_last", 64'(b_rlast), 0);
    chk("chain_w1_busy", 64'(b_busy), 1);
    chk("chain_w1_cnt_held", 64'(b_count), 1);
    up_valid = 1'b0; left_valid = 1'b0;
    res_in_b = 32'd13; res_in_last_b = 1'b1;
    step();
    chk("chain_w2_res", 64'($signed(b_res)), 13);
    chk("chain_w2_valid", 64'(b_rvld), 1);
    chk("chain_w2_last", 64'(b_rlast), 1);
    chk("chain_w2_busy", 64'(b_busy), 0);
    chk("chain_w2_cnt", 64'(b_count), 0);
    res_in_valid_b = 1'b0; res_in_last_b = 1'b0;
    step();
    chk("chain_after_valid", 64'(b_rvld), 0);
    chk("chain_after_last", 64'(b_rlast), 0);

    // last flag without valid is not a last word; then reset lands mid-DRAIN
    drain_b = 1'b1;
    step();
    chk("mid_busy", 64'(b_busy), 1);
    drain_b = 1'b0; res_in_last_b = 1'b1; res_in_valid_b = 1'b0;
    step();
    chk("mid_nolast_valid", 64'(b_rvld), 0);
    chk("mid_nolast_last", 64'(b_rlast), 0);
    chk("mid_nolast_busy", 64'(b_busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(b_rvld), 0);
    chk("mid_rst_busy", 64'(b_busy), 0);
    chk("mid_rst_res", 64'(b_res), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    res_in_last_b = 1'b0;
    step();
    chk("post_rst_busy", 64'(b_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
